// File: rtl/hamming_pkg.sv
// Shared sizing helpers, bit-layout mapping and status type for the Hamming corrector.
// Build option: define HAMMING_SECDED_EN to add the overall-parity bit (SECDED).
package hamming_pkg;

    function automatic int calc_n(input int r);
        return (1 << r) - 1;
    endfunction

    function automatic int calc_k(input int r);
        return calc_n(r) - r;
    endfunction

    function automatic int calc_cw(input int r);
`ifdef HAMMING_SECDED_EN
        return calc_n(r) + 1;
`else
        return calc_n(r);
`endif
    endfunction

    // 1-based code position of data bit idx: the idx-th position that is not a power of two.
    function automatic int data_pos(input int r, input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p <= calc_n(r); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    typedef struct packed {
        logic corregido;
        logic doble;
    } status_t;

endpackage

// File: rtl/hamming_sindrome.sv
// Combinational syndrome generator; with HAMMING_SECDED_EN it also reports the overall
// parity mismatch across all code bits including the extra parity bit.
module hamming_sindrome
    import hamming_pkg::*;
#(
    parameter int R = 3
) (
    input  logic [calc_cw(R)-1:0] i_codeword,
    output logic [R-1:0]          o_sindrome
`ifdef HAMMING_SECDED_EN
    ,
    output logic                  o_paridad
`endif
);

    localparam int N = calc_n(R);

    always_comb begin
        o_sindrome = '0;
        for (int j = 0; j < R; j++) begin
            for (int p = 1; p <= N; p++) begin
                if (p[j]) o_sindrome[j] = o_sindrome[j] ^ i_codeword[p-1];
            end
        end
    end

`ifdef HAMMING_SECDED_EN
    assign o_paridad = ^i_codeword;
`endif

endmodule

// File: rtl/hamming_corrector_pipe.sv
// Two-stage elastic Hamming single-error corrector with a saturating corrected-word counter.
// Build option: HAMMING_SECDED_EN adds double-error detection via an overall parity bit.
module hamming_corrector_pipe
    import hamming_pkg::*;
#(
    parameter int R     = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [calc_cw(R)-1:0] in_codeword,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [calc_k(R)-1:0]  out_data,
    output logic [R-1:0]          out_sindrome,
    output logic                  out_corregido,
    output logic                  out_doble,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt_corregidos
);

    localparam int K = calc_k(R);

    logic [R-1:0]     w_sind;
    logic [K-1:0]     w_data_raw;
    logic [K-1:0]     w_data_fix;
    logic             w_flip;
    status_t          w_stat;
    logic             w_s2_adv;
    logic             w_cnt_inc;

    logic             r_vld_p1;
    logic [K-1:0]     r_data_p1;
    logic [R-1:0]     r_sind_p1;
    logic             r_vld_p2;
    logic [K-1:0]     r_data_p2;
    logic [R-1:0]     r_sind_p2;
    status_t          r_stat_p2;
    logic [CNT_W-1:0] r_cnt;

`ifdef HAMMING_SECDED_EN
    logic             w_par;
    logic             r_par_p1;
`endif

    hamming_sindrome #(.R(R)) u_sindrome (
        .i_codeword (in_codeword),
        .o_sindrome (w_sind)
`ifdef HAMMING_SECDED_EN
        ,
        .o_paridad  (w_par)
`endif
    );

    // Only data positions are carried forward; parity-bit errors need no repair.
    always_comb begin
        w_data_raw = '0;
        for (int k = 0; k < K; k++) begin
            w_data_raw[k] = in_codeword[data_pos(R, k) - 1];
        end
    end

    assign w_s2_adv  = ~r_vld_p2 | out_ready;
    assign in_ready  = ~r_vld_p1 | w_s2_adv;

    // ---- Stage 1: codeword data bits and syndrome ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_sind_p1 <= '0;
`ifdef HAMMING_SECDED_EN
            r_par_p1  <= 1'b0;
`endif
        end else if (in_ready) begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_data_p1 <= w_data_raw;
                r_sind_p1 <= w_sind;
`ifdef HAMMING_SECDED_EN
                r_par_p1  <= w_par;
`endif
            end
        end
    end

    always_comb begin
`ifdef HAMMING_SECDED_EN
        // s!=0 with even overall parity is a double error: report it, leave data alone.
        w_flip           = (|r_sind_p1) & r_par_p1;
        w_stat.corregido = r_par_p1;
        w_stat.doble     = (|r_sind_p1) & ~r_par_p1;
`else
        w_flip           = |r_sind_p1;
        w_stat.corregido = |r_sind_p1;
        w_stat.doble     = 1'b0;
`endif
        w_data_fix = r_data_p1;
        for (int k = 0; k < K; k++) begin
            if (w_flip && (r_sind_p1 == R'(data_pos(R, k)))) w_data_fix[k] = ~r_data_p1[k];
        end
    end

    // ---- Stage 2: corrected data and status ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_sind_p2 <= '0;
            r_stat_p2 <= '0;
        end else if (w_s2_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_data_fix;
                r_sind_p2 <= r_sind_p1;
                r_stat_p2 <= w_stat;
            end
        end
    end

    assign out_valid     = r_vld_p2;
    assign out_data      = r_data_p2;
    assign out_sindrome  = r_sind_p2;
    assign out_corregido = r_stat_p2.corregido;
    assign out_doble     = r_stat_p2.doble;

    assign w_cnt_inc = r_vld_p2 & out_ready & r_stat_p2.corregido & ~(&r_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_corregidos = r_cnt;

endmodule
